// File: rtl/neuron_ctrl_pkg.sv
// Shared definitions for the neuron evaluation controller: state encoding
// and the offset bus width helper.
package neuron_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_ACC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // A single input still needs a one-bit select bus.
    function automatic int offset_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/neuron_offset_counter.sv
// Input/weight offset counter: steps 0..N-1 while enabled and flags the
// final offset so the controller can leave the accumulate phase.
module neuron_offset_counter
    import neuron_ctrl_pkg::*;
#(
    parameter int N  = 10,
    parameter int OW = offset_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [OW-1:0] count,
    output logic          last
);

    localparam logic [OW-1:0] LAST_VAL = OW'(N - 1);

    logic [OW-1:0] count_q;
    logic [OW-1:0] count_d;

    // Returning to zero on the last offset keeps the counter inside 0..N-1.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == LAST_VAL) begin
                count_d = '0;
            end else begin
                count_d = count_q + OW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_VAL);

endmodule

// File: rtl/neuron_controller.sv
// Sequences one neuron datapath: clear, accumulate N offsets, present result.
// Optional NEURON_CTRL_ABORT_EN adds an abort input that cancels CLR/ACC.
module neuron_controller
    import neuron_ctrl_pkg::*;
#(
    parameter int N  = 10,
    parameter int OW = offset_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hidden_in,
`ifdef NEURON_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic [OW-1:0] offset,
    output logic          ld,
    output logic          clr,
    output logic          ready,
    output logic          hidden,
    output logic          busy,
    output logic          done
);

    state_t state_q;
    state_t state_d;
    logic   hidden_q;
    logic   hidden_d;
    logic   accept;
    logic   cnt_en;
    logic   cnt_clr;
    logic   cnt_last;
    logic [OW-1:0] count;

    neuron_offset_counter #(.N(N), .OW(OW)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .count (count),
        .last  (cnt_last)
    );

    // Start is only honoured between evaluations; OUT may chain straight into CLR.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                state_d = ST_ACC;
`ifdef NEURON_CTRL_ABORT_EN
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_ACC: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_d = ST_OUT;
                end
`ifdef NEURON_CTRL_ABORT_EN
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_OUT: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_CLR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        hidden_d = accept ? hidden_in : hidden_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            hidden_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hidden_q <= hidden_d;
        end
    end

    assign offset = (state_q == ST_ACC) ? count : '0;
    assign ld     = (state_q == ST_ACC);
    assign clr    = (state_q == ST_CLR);
    assign ready  = (state_q == ST_OUT);
    assign done   = (state_q == ST_OUT);
    assign busy   = (state_q != ST_IDLE);
    assign hidden = hidden_q;

endmodule

// File: tb/tb_neuron_controller.sv
// Directed bench for neuron_controller with N=10 and N=1 instances;
// abort scenario is built when NEURON_CTRL_ABORT_EN is defined.
module tb_neuron_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start1;
    logic       hidden_in;
    logic [3:0] offset;
    logic       ld, clr, ready, hidden, busy, done;
    logic [0:0] offset1;
    logic       ld1, clr1, ready1, hidden1, busy1, done1;
`ifdef NEURON_CTRL_ABORT_EN
    logic       abort;
    logic       abort1;
`endif

    int checks = 0;
    int errors = 0;

    // Observation order: {busy, done, ready, hidden, clr, ld, offset}
    logic [9:0] obs10;
    logic [6:0] obs1;
    assign obs10 = {busy, done, ready, hidden, clr, ld, offset};
    assign obs1  = {busy1, done1, ready1, hidden1, clr1, ld1, offset1};

    always #5 clk = ~clk;

    neuron_controller #(.N(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hidden_in (hidden_in),
`ifdef NEURON_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .offset    (offset),
        .ld        (ld),
        .clr       (clr),
        .ready     (ready),
        .hidden    (hidden),
        .busy      (busy),
        .done      (done)
    );

    neuron_controller #(.N(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .hidden_in (hidden_in),
`ifdef NEURON_CTRL_ABORT_EN
        .abort     (abort1),
`endif
        .offset    (offset1),
        .ld        (ld1),
        .clr       (clr1),
        .ready     (ready1),
        .hidden    (hidden1),
        .busy      (busy1),
        .done      (done1)
    );

    task automatic test_reset();
        logic [9:0] exp;
        rst = 1'b0; start = 1'b0; start1 = 1'b0; hidden_in = 1'b0;
`ifdef NEURON_CTRL_ABORT_EN
        abort = 1'b0; abort1 = 1'b0;
`endif
        #2;
        checks++;
        if (obs10 !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_n10 got %b exp %b", obs10, 10'b0);
        end
        checks++;
        if (obs1 !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_n1 got %b exp %b", obs1, 7'b0);
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs10 !== 10'b0) begin
                errors++;
                $display("[TB] FAIL idle_after_reset got %b exp %b", obs10, 10'b0);
            end
        end
        // Reset in the middle of accumulation
        hidden_in = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        checks++;
        if (obs10 !== exp) begin
            errors++;
            $display("[TB] FAIL rst_pre_clr got %b exp %b", obs10, exp);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, i[3:0]};
            checks++;
            if (obs10 !== exp) begin
                errors++;
                $display("[TB] FAIL rst_pre_acc%0d got %b exp %b", i, obs10, exp);
            end
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs10 !== 10'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_mid_acc got %b exp %b", obs10, 10'b0);
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs10 !== 10'b0) begin
                errors++;
                $display("[TB] FAIL idle_after_mid_reset got %b exp %b", obs10, 10'b0);
            end
        end
    endtask

    task automatic test_single();
        logic [9:0] exp;
        hidden_in = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0; hidden_in = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        checks++;
        if (obs10 !== exp) begin
            errors++;
            $display("[TB] FAIL single_clr got %b exp %b", obs10, exp);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, i[3:0]};
            checks++;
            if (obs10 !== exp) begin
                errors++;
                $display("[TB] FAIL single_acc%0d got %b exp %b", i, obs10, exp);
            end
        end
        @(negedge clk);
        exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs10 !== exp) begin
            errors++;
            $display("[TB] FAIL single_out got %b exp %b", obs10, exp);
        end
        @(negedge clk);
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs10 !== exp) begin
            errors++;
            $display("[TB] FAIL single_idle got %b exp %b", obs10, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        logic [2:0] h;
        h = 3'b010;
        start = 1'b1; hidden_in = h[0];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp = {1'b1, 1'b0, 1'b0, h[k], 1'b1, 1'b0, 4'd0};
            checks++;
            if (obs10 !== exp) begin
                errors++;
                $display("[TB] FAIL b2b%0d_clr got %b exp %b", k, obs10, exp);
            end
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                exp = {1'b1, 1'b0, 1'b0, h[k], 1'b0, 1'b1, i[3:0]};
                checks++;
                if (obs10 !== exp) begin
                    errors++;
                    $display("[TB] FAIL b2b%0d_acc%0d got %b exp %b", k, i, obs10, exp);
                end
            end
            @(negedge clk);
            exp = {1'b1, 1'b1, 1'b1, h[k], 1'b0, 1'b0, 4'd0};
            checks++;
            if (obs10 !== exp) begin
                errors++;
                $display("[TB] FAIL b2b%0d_out got %b exp %b", k, obs10, exp);
            end
            if (k < 2) hidden_in = h[k+1];
            else start = 1'b0;
        end
        @(negedge clk);
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs10 !== exp) begin
            errors++;
            $display("[TB] FAIL b2b_idle got %b exp %b", obs10, exp);
        end
    endtask

    task automatic test_ignored_start();
        logic [9:0] exp;
        hidden_in = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0; hidden_in = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        checks++;
        if (obs10 !== exp) begin
            errors++;
            $display("[TB] FAIL ign_clr got %b exp %b", obs10, exp);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, i[3:0]};
            checks++;
            if (obs10 !== exp) begin
                errors++;
                $display("[TB] FAIL ign_acc%0d got %b exp %b", i, obs10, exp);
            end
            start = (i == 3 || i == 7);
        end
        @(negedge clk);
        exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs10 !== exp) begin
            errors++;
            $display("[TB] FAIL ign_out got %b exp %b", obs10, exp);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
            checks++;
            if (obs10 !== exp) begin
                errors++;
                $display("[TB] FAIL ign_no_extra_clr got %b exp %b", obs10, exp);
            end
        end
    endtask

    task automatic test_n1();
        logic [6:0] exp;
        hidden_in = 1'b1; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs1 !== exp) begin
            errors++;
            $display("[TB] FAIL n1_clr got %b exp %b", obs1, exp);
        end
        @(negedge clk);
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs1 !== exp) begin
            errors++;
            $display("[TB] FAIL n1_acc got %b exp %b", obs1, exp);
        end
        @(negedge clk);
        exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs1 !== exp) begin
            errors++;
            $display("[TB] FAIL n1_out got %b exp %b", obs1, exp);
        end
        @(negedge clk);
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs1 !== exp) begin
            errors++;
            $display("[TB] FAIL n1_idle got %b exp %b", obs1, exp);
        end
    endtask

`ifdef NEURON_CTRL_ABORT_EN
    task automatic test_abort();
        logic [9:0] exp;
        hidden_in = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, i[3:0]};
            checks++;
            if (obs10 !== exp) begin
                errors++;
                $display("[TB] FAIL abort_pre_acc%0d got %b exp %b", i, obs10, exp);
            end
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if (obs10 !== 10'b0) begin
            errors++;
            $display("[TB] FAIL abort_to_idle got %b exp %b", obs10, 10'b0);
        end
        @(negedge clk);
        checks++;
        if (obs10 !== 10'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_done got %b exp %b", obs10, 10'b0);
        end
        hidden_in = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        checks++;
        if (obs10 !== exp) begin
            errors++;
            $display("[TB] FAIL post_abort_clr got %b exp %b", obs10, exp);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, i[3:0]};
            checks++;
            if (obs10 !== exp) begin
                errors++;
                $display("[TB] FAIL post_abort_acc%0d got %b exp %b", i, obs10, exp);
            end
        end
        @(negedge clk);
        exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        checks++;
        if (obs10 !== exp) begin
            errors++;
            $display("[TB] FAIL post_abort_out got %b exp %b", obs10, exp);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored_start();
        test_n1();
`ifdef NEURON_CTRL_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
